// File: rtl/window_vote_scanner.sv
// Scans an image in WIN x WIN windows (column strips), counts the ones in each
// window and flags windows whose count exceeds a threshold latched at start.
module window_vote_scanner #(
   parameter int WIN     = 3,
   parameter int STRIDE  = 3,
   parameter int IMG_W   = 240,
   parameter int IMG_H   = 180,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [6:0]       threshold,
   output logic             rd_en,
   output logic [7:0]       x_addr,
   output logic [7:0]       y_addr,
   input  logic             rd_data,
   output logic             win_valid,
   output logic [6:0]       win_sum,
   output logic             win_active,
   output logic [7:0]       win_col,
   output logic [7:0]       win_row,
   output logic [CNT_W-1:0] active_count,
   output logic             busy,
   output logic             done
);

   localparam int NWX = (IMG_W - WIN) / STRIDE + 1;
   localparam int NWY = (IMG_H - WIN) / STRIDE + 1;
   localparam logic [2:0]       PIX_LAST = 3'(WIN - 1);
   localparam logic [7:0]       COL_LAST = 8'(NWX - 1);
   localparam logic [7:0]       ROW_LAST = 8'(NWY - 1);
   localparam logic [7:0]       STEP     = 8'(STRIDE);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
   state_t state, nextState;

   logic [2:0] pixCol, pixRow;
   logic [7:0] winColCnt, winRowCnt, xBase, yBase;
   logic [6:0] thrLatched, acc, sumNext;
   logic       accept, winFinal;

   logic       vld_p0, first_p0, last_p0, final_p0;
   logic       vld_p   [MEM_LAT:1];
   logic       first_p [MEM_LAT:1];
   logic       last_p  [MEM_LAT:1];
   logic       final_p [MEM_LAT:1];
   logic [7:0] col_p   [MEM_LAT:1];
   logic [7:0] row_p   [MEM_LAT:1];

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign accept   = start && (state == IDLE);
   assign busy     = (state != IDLE);
   assign rd_en    = (state == SCAN);
   assign x_addr   = xBase + 8'(pixCol);
   assign y_addr   = yBase + 8'(pixRow);
   assign vld_p0   = rd_en;
   assign first_p0 = (pixCol == 3'd0) && (pixRow == 3'd0);
   assign last_p0  = (pixCol == PIX_LAST) && (pixRow == PIX_LAST);
   assign final_p0 = last_p0 && (winColCnt == COL_LAST) && (winRowCnt == ROW_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = SCAN;
         SCAN:    if (final_p0) nextState = DRAIN;
         DRAIN:   if (win_valid && winFinal) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) thrLatched <= '0;
      else if (accept) thrLatched <= threshold;
   end

   // Stage p0: read-address generation; counters freeze on the final read so addresses hold
   always_ff @(posedge clk) begin
      if (reset || accept) begin
         pixCol    <= '0;
         pixRow    <= '0;
         winColCnt <= '0;
         winRowCnt <= '0;
         xBase     <= '0;
         yBase     <= '0;
      end else if (rd_en && !final_p0) begin
         if (pixCol != PIX_LAST) begin
            pixCol <= pixCol + 3'd1;
         end else begin
            pixCol <= '0;
            if (pixRow != PIX_LAST) begin
               pixRow <= pixRow + 3'd1;
            end else begin
               pixRow <= '0;
               if (winRowCnt != ROW_LAST) begin
                  winRowCnt <= winRowCnt + 8'd1;
                  yBase     <= yBase + STEP;
               end else begin
                  winRowCnt <= '0;
                  yBase     <= '0;
                  winColCnt <= winColCnt + 8'd1;
                  xBase     <= xBase + STEP;
               end
            end
         end
      end
   end

   // Stages p1..pMEM_LAT: window tags travel with the outstanding read
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i <= MEM_LAT; i++) begin
            vld_p[i]   <= 1'b0;
            first_p[i] <= 1'b0;
            last_p[i]  <= 1'b0;
            final_p[i] <= 1'b0;
            col_p[i]   <= '0;
            row_p[i]   <= '0;
         end
      end else begin
         vld_p[1]   <= vld_p0;
         first_p[1] <= first_p0;
         last_p[1]  <= last_p0;
         final_p[1] <= final_p0;
         col_p[1]   <= winColCnt;
         row_p[1]   <= winRowCnt;
         for (int i = 2; i <= MEM_LAT; i++) begin
            vld_p[i]   <= vld_p[i-1];
            first_p[i] <= first_p[i-1];
            last_p[i]  <= last_p[i-1];
            final_p[i] <= final_p[i-1];
            col_p[i]   <= col_p[i-1];
            row_p[i]   <= row_p[i-1];
         end
      end
   end

   always_comb sumNext = (first_p[MEM_LAT] ? 7'd0 : acc) + 7'(rd_data);

   // Final stage: accumulate aligned pixel, publish the window result on its last pixel
   always_ff @(posedge clk) begin
      if (vld_p[MEM_LAT]) acc <= sumNext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_valid    <= 1'b0;
         winFinal     <= 1'b0;
         done         <= 1'b0;
         win_sum      <= '0;
         win_active   <= 1'b0;
         win_col      <= '0;
         win_row      <= '0;
         active_count <= '0;
      end else begin
         win_valid <= vld_p[MEM_LAT] && last_p[MEM_LAT];
         winFinal  <= vld_p[MEM_LAT] && final_p[MEM_LAT];
         done      <= win_valid && winFinal;
         if (vld_p[MEM_LAT] && last_p[MEM_LAT]) begin
            win_sum    <= sumNext;
            win_active <= (sumNext > thrLatched);
            win_col    <= col_p[MEM_LAT];
            win_row    <= row_p[MEM_LAT];
         end
         if (accept)
            active_count <= '0;
         else if (vld_p[MEM_LAT] && last_p[MEM_LAT] && (sumNext > thrLatched))
            active_count <= satInc(active_count);
      end
   end

endmodule

// File: tb/tb_window_vote_scanner.sv
// Bench for window_vote_scanner: three configurations driven by directed and
// random images, checked cycle by cycle against a window-level reference model.
module tb_window_vote_scanner;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       start     [NI];
   logic [6:0] threshold [NI];
   logic       rdEn      [NI];
   logic [7:0] xAddr     [NI];
   logic [7:0] yAddr     [NI];
   logic       rdData    [NI];
   logic       winValid  [NI];
   logic [6:0] winSum    [NI];
   logic       winActive [NI];
   logic [7:0] winCol    [NI];
   logic [7:0] winRow    [NI];
   logic       busy      [NI];
   logic       done      [NI];
   logic [12:0] ac0, ac2;
   logic [1:0]  ac1;

   int   pWin [NI], pStr [NI], pIw [NI], pIh [NI], pLat [NI], pCnt [NI];
   bit   img [NI][16][16];
   logic memPipe [NI][4];
   logic [7:0] lastX [NI], lastY [NI];
   int   nChecks = 0, nPass = 0, nFail = 0, curInst = 0, curCyc = 0;

   always #5 clk = ~clk;

   window_vote_scanner #(.WIN(3), .STRIDE(3), .IMG_W(7), .IMG_H(6), .MEM_LAT(1), .CNT_W(13)) dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .threshold(threshold[0]),
      .rd_en(rdEn[0]), .x_addr(xAddr[0]), .y_addr(yAddr[0]), .rd_data(rdData[0]),
      .win_valid(winValid[0]), .win_sum(winSum[0]), .win_active(winActive[0]),
      .win_col(winCol[0]), .win_row(winRow[0]), .active_count(ac0),
      .busy(busy[0]), .done(done[0]));

   window_vote_scanner #(.WIN(3), .STRIDE(1), .IMG_W(4), .IMG_H(4), .MEM_LAT(3), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .threshold(threshold[1]),
      .rd_en(rdEn[1]), .x_addr(xAddr[1]), .y_addr(yAddr[1]), .rd_data(rdData[1]),
      .win_valid(winValid[1]), .win_sum(winSum[1]), .win_active(winActive[1]),
      .win_col(winCol[1]), .win_row(winRow[1]), .active_count(ac1),
      .busy(busy[1]), .done(done[1]));

   window_vote_scanner #(.WIN(4), .STRIDE(3), .IMG_W(11), .IMG_H(9), .MEM_LAT(2), .CNT_W(13)) dut2 (
      .clk(clk), .reset(reset), .start(start[2]), .threshold(threshold[2]),
      .rd_en(rdEn[2]), .x_addr(xAddr[2]), .y_addr(yAddr[2]), .rd_data(rdData[2]),
      .win_valid(winValid[2]), .win_sum(winSum[2]), .win_active(winActive[2]),
      .win_col(winCol[2]), .win_row(winRow[2]), .active_count(ac2),
      .busy(busy[2]), .done(done[2]));

   function automatic bit pixAt(int k, logic [7:0] x, logic [7:0] y);
      if (x < 8'd16 && y < 8'd16) return img[k][x][y];
      return 1'b0;
   endfunction

   // Pixel memory: returns the addressed pixel MEM_LAT cycles after the read, noise otherwise
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         for (int j = 3; j > 0; j--) memPipe[k][j] <= memPipe[k][j-1];
         memPipe[k][0] <= rdEn[k] ? pixAt(k, xAddr[k], yAddr[k]) : 1'($urandom);
      end
   end
   assign rdData[0] = memPipe[0][0];
   assign rdData[1] = memPipe[1][2];
   assign rdData[2] = memPipe[2][1];

   function automatic logic [31:0] acOf(int k);
      case (k)
         0:       return {19'd0, ac0};
         1:       return {30'd0, ac1};
         default: return {19'd0, ac2};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      assert (got === exp) nPass++;
      else begin
         nFail++;
         $error("FAIL %s inst%0d cyc%0d: observed %0d expected %0d", tag, curInst, curCyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input int k);
      curInst = k;
      check("idle_rd_en", 32'(rdEn[k]), 0);
      check("idle_x_addr", 32'(xAddr[k]), 0);
      check("idle_y_addr", 32'(yAddr[k]), 0);
      check("idle_win_valid", 32'(winValid[k]), 0);
      check("idle_win_sum", 32'(winSum[k]), 0);
      check("idle_win_active", 32'(winActive[k]), 0);
      check("idle_win_col", 32'(winCol[k]), 0);
      check("idle_win_row", 32'(winRow[k]), 0);
      check("idle_active_count", acOf(k), 0);
      check("idle_busy", 32'(busy[k]), 0);
      check("idle_done", 32'(done[k]), 0);
   endtask

   task automatic clearAddrModel();
      for (int k = 0; k < NI; k++) begin
         lastX[k] = 8'd0;
         lastY[k] = 8'd0;
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      for (int k = 0; k < NI; k++) start[k] = 1'b0;
      step();
      step();
      reset = 1'b0;
      clearAddrModel();
   endtask

   // mode 0 zeros, 1 ones, 2 checkerboard with (0,0)=1, 3 random
   task automatic fill(input int k, input int mode);
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            case (mode)
               0:       img[k][x][y] = 1'b0;
               1:       img[k][x][y] = 1'b1;
               2:       img[k][x][y] = ((x + y) % 2 == 0);
               default: img[k][x][y] = 1'($urandom_range(0, 1));
            endcase
   endtask

   // One full scan; busyStartAt pulses start during that cycle (-1 = last busy cycle, 0 = never)
   task automatic runScan(input int k, input logic [6:0] thr, input int busyStartAt);
      int w2, nwx, nwy, nWin, nRd, lat, cntMax, nAct, t, w, s, bsa;
      int expX[$], expY[$], expSum[$], expCol[$], expRow[$];
      w2  = pWin[k] * pWin[k];
      nwx = (pIw[k] - pWin[k]) / pStr[k] + 1;
      nwy = (pIh[k] - pWin[k]) / pStr[k] + 1;
      nWin = nwx * nwy;
      nRd  = nWin * w2;
      lat  = pLat[k];
      cntMax = (1 << pCnt[k]) - 1;
      bsa = (busyStartAt < 0) ? nRd + lat + 1 : busyStartAt;
      for (int wc = 0; wc < nwx; wc++)
         for (int wr = 0; wr < nwy; wr++) begin
            s = 0;
            for (int r = 0; r < pWin[k]; r++)
               for (int c = 0; c < pWin[k]; c++) begin
                  expX.push_back(wc * pStr[k] + c);
                  expY.push_back(wr * pStr[k] + r);
                  s += int'(img[k][wc * pStr[k] + c][wr * pStr[k] + r]);
               end
            expSum.push_back(s);
            expCol.push_back(wc);
            expRow.push_back(wr);
         end
      curInst = k;
      threshold[k] = thr;
      start[k] = 1'b1;
      step();
      start[k] = 1'b0;
      threshold[k] = 7'($urandom);
      nAct = 0;
      for (int cyc = 1; cyc <= nRd + lat + 5; cyc++) begin
         curCyc = cyc;
         t = cyc - lat - 1;
         w = -1;
         if (t > 0 && t % w2 == 0 && t / w2 <= nWin) w = t / w2 - 1;
         if (w >= 0 && expSum[w] > int'(thr)) nAct++;
         if (cyc <= nRd) begin
            lastX[k] = 8'(expX[cyc-1]);
            lastY[k] = 8'(expY[cyc-1]);
         end
         check("rd_en", 32'(rdEn[k]), 32'(cyc <= nRd));
         check("x_addr", 32'(xAddr[k]), 32'(lastX[k]));
         check("y_addr", 32'(yAddr[k]), 32'(lastY[k]));
         check("win_valid", 32'(winValid[k]), 32'(w >= 0));
         if (w >= 0) begin
            check("win_sum", 32'(winSum[k]), expSum[w]);
            check("win_active", 32'(winActive[k]), 32'(expSum[w] > int'(thr)));
            check("win_col", 32'(winCol[k]), expCol[w]);
            check("win_row", 32'(winRow[k]), expRow[w]);
         end
         check("active_count", acOf(k), (nAct > cntMax) ? cntMax : nAct);
         check("busy", 32'(busy[k]), 32'(cyc <= nRd + lat + 1));
         check("done", 32'(done[k]), 32'(cyc == nRd + lat + 2));
         start[k] = (cyc == bsa);
         step();
      end
      start[k] = 1'b0;
   endtask

   task automatic abortScan(input int k, input int cut);
      curInst = k;
      threshold[k] = 7'd4;
      start[k] = 1'b1;
      step();
      start[k] = 1'b0;
      for (int cyc = 1; cyc < cut; cyc++) step();
      curCyc = cut;
      check("rd_en_before_abort", 32'(rdEn[k]), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      clearAddrModel();
      for (int c = 0; c < 60; c++) begin
         curCyc = c;
         for (int j = 0; j < NI; j++) checkIdle(j);
         step();
      end
   endtask

   task automatic resetWithStart();
      curInst = 0;
      reset = 1'b1;
      start[0] = 1'b1;
      threshold[0] = 7'd4;
      step();
      reset = 1'b0;
      start[0] = 1'b0;
      clearAddrModel();
      for (int c = 0; c < 4; c++) begin
         curCyc = c;
         check("busy_after_reset_start", 32'(busy[0]), 0);
         check("rd_en_after_reset_start", 32'(rdEn[0]), 0);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      pWin = '{3, 3, 4};
      pStr = '{3, 1, 3};
      pIw  = '{7, 4, 11};
      pIh  = '{6, 4, 9};
      pLat = '{1, 3, 2};
      pCnt = '{13, 2, 13};
      reset = 1'b1;
      for (int k = 0; k < NI; k++) begin
         start[k] = 1'b0;
         threshold[k] = 7'd0;
      end
      doReset();
      for (int k = 0; k < NI; k++) checkIdle(k);

      fill(0, 1); runScan(0, 7'd4, 0);
      fill(0, 2); runScan(0, 7'd4, 10);
      runScan(0, 7'd4, -1);
      fill(0, 1); runScan(0, 7'd9, 0);
      runScan(0, 7'd8, 0);
      for (int i = 0; i < 3; i++) begin
         fill(0, 3);
         runScan(0, 7'($urandom_range(0, 9)), 0);
      end
      fill(0, 1); abortScan(0, 21);
      fill(0, 3); runScan(0, 7'd4, 0);
      resetWithStart();

      fill(1, 1); runScan(1, 7'd4, 0);
      fill(1, 0); runScan(1, 7'd0, 0);
      for (int i = 0; i < 2; i++) begin
         fill(1, 3);
         runScan(1, 7'($urandom_range(0, 9)), 0);
      end

      fill(2, 1); runScan(2, 7'd15, 0);
      fill(2, 3); runScan(2, 7'($urandom_range(0, 16)), 30);
      for (int i = 0; i < 2; i++) begin
         fill(2, 3);
         runScan(2, 7'($urandom_range(0, 16)), 0);
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
